// File: rtl/load_sched_pkg.sv
// Shared definitions for the load/run scheduler family.
// State encoding is fixed so that waveform decoders and later arbiters agree on it.
package load_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set req bit after ptr, wrapping modulo NREQ.
// Latency: combinational.
// Backpressure: none; valid is low when no request is pending.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            valid,
    output logic [PW-1:0]   owner,
    output logic [NREQ-1:0] mask
);

    int idx;

    always_comb begin
        valid = 1'b0;
        owner = '0;
        mask  = '0;
        idx   = 0;
        // Walk from the farthest offset down so the nearest requester wins.
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                valid = 1'b1;
                owner = idx[PW-1:0];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            mask[i] = valid && (owner == PW'(i));
        end
    end

endmodule

// File: rtl/load_sched_rr.sv
// Round-robin owner of one shared loadable register: load seed, run RUN_CYCLES, return value.
// Latency: RUN_CYCLES+2 cycles from the IDLE sample to done; one transaction per RUN_CYCLES+3.
// Backpressure: requests are levels; losers simply wait in IDLE until picked.
module load_sched_rr
    import load_sched_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 4,
    parameter int RUN_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] seed,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      result,
    output logic                  busy,
    output logic                  reg_load,
    output logic [WIDTH-1:0]      reg_in,
    input  logic [WIDTH-1:0]      reg_out
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(RUN_CYCLES + 1);

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [NREQ-1:0] owner_mask;
    logic [CW-1:0]   cnt;
    logic            pick_vld;
    logic [PW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_mask;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_vld),
        .owner (pick_idx),
        .mask  (pick_mask)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_vld) state_nx = LOAD;
            LOAD:    state_nx = RUN;
            RUN:     if (cnt == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= PW'(NREQ - 1);
            owner      <= '0;
            owner_mask <= '0;
            reg_in     <= '0;
            cnt        <= '0;
            result     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner      <= pick_idx;
                        owner_mask <= pick_mask;
                        reg_in     <= seed[int'(pick_idx)*WIDTH +: WIDTH];
                    end
                end
                LOAD: cnt <= CW'(RUN_CYCLES - 1);
                RUN: begin
                    // reg_out here reflects RUN_CYCLES-1 advances past the loaded seed.
                    if (cnt == '0) begin
                        result <= reg_out;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: ptr <= owner;
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign grant    = busy ? owner_mask : '0;
    assign done     = (state == DONE) ? owner_mask : '0;
    assign reg_load = (state == LOAD);

endmodule

// File: tb/tb_load_sched_rr.sv
// Bench for load_sched_rr: shared register modelled as a 4-bit loadable up-counter,
// transaction-level reference model checked every cycle plus directed literal checks.
module tb_load_sched_rr;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int R     = 8;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] seed;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      result;
    logic                  busy;
    logic                  reg_load;
    logic [WIDTH-1:0]      reg_in;
    logic [WIDTH-1:0]      reg_out;

    int n_vec = 0;
    int n_err = 0;

    load_sched_rr #(.NREQ(NREQ), .WIDTH(WIDTH), .RUN_CYCLES(R)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .seed     (seed),
        .grant    (grant),
        .done     (done),
        .result   (result),
        .busy     (busy),
        .reg_load (reg_load),
        .reg_in   (reg_in),
        .reg_out  (reg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared register the scheduler drives.
    always @(posedge clk) begin
        if (reg_load) reg_out <= reg_in;
        else          reg_out <= reg_out + 4'd1;
    end
    initial reg_out = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference model: m_el is cycles elapsed since grant (-1 when no transaction).
    int         m_el;
    int         m_owner;
    int         m_ptr;
    logic [3:0] m_seed;
    logic [3:0] m_result;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_el     <= -1;
            m_owner  <= 0;
            m_ptr    <= NREQ - 1;
            m_seed   <= '0;
            m_result <= '0;
        end else if (m_el < 0) begin
            if (pick(req, m_ptr) >= 0) begin
                m_owner <= pick(req, m_ptr);
                m_seed  <= seed[pick(req, m_ptr)*WIDTH +: WIDTH];
                m_el    <= 0;
            end
        end else if (m_el == R + 1) begin
            m_ptr <= m_owner;
            m_el  <= -1;
        end else begin
            if (m_el == R) m_result <= m_seed + 4'(R - 1);
            m_el <= m_el + 1;
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] oh;
        oh = (m_el >= 0) ? NREQ'(1 << m_owner) : '0;
        check("model_grant",  32'(grant),    32'(oh));
        check("model_done",   32'(done),     32'((m_el == R + 1) ? oh : '0));
        check("model_load",   32'(reg_load), 32'(m_el == 0));
        check("model_regin",  32'(reg_in),   32'(m_seed));
        check("model_busy",   32'(busy),     32'(m_el >= 0));
        check("model_result", 32'(result),   32'(m_result));
    end

    // Starts and ends at the negedge of an IDLE cycle; req is dropped mid-RUN.
    task automatic do_txn(input int idx, input logic [3:0] sv, input logic [3:0] exp_res);
        req = NREQ'(1 << idx);
        seed[idx*WIDTH +: WIDTH] = sv;
        @(negedge clk);
        check("txn_grant", 32'(grant), 32'(1 << idx));
        check("txn_load",  32'(reg_load), 32'd1);
        check("txn_regin", 32'(reg_in), 32'(sv));
        seed = ~seed;
        repeat (3) @(negedge clk);
        req = '0;
        repeat (5) @(negedge clk);
        check("txn_no_early_done", 32'(done), 32'd0);
        @(negedge clk);
        check("txn_done",   32'(done),   32'(1 << idx));
        check("txn_result", 32'(result), 32'(exp_res));
        @(negedge clk);
        check("txn_idle_busy",  32'(busy),  32'd0);
        check("txn_idle_grant", 32'(grant), 32'd0);
    endtask

    initial begin
        rst  = 1'b0;
        req  = '0;
        seed = '0;
        #3;
        check("rst_grant",  32'(grant),  32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_txn(2, 4'h3, 4'hA);
        do_txn(1, 4'hE, 4'h5);
        do_txn(3, 4'h9, 4'h0);

        // Everyone requesting: rotate 0,1,2,3,0 starting from the reset pointer.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            check("rr_grant", 32'(grant), 32'(1 << (g % 4)));
            repeat (9) @(negedge clk);
            check("rr_done", 32'(done), 32'(1 << (g % 4)));
            @(negedge clk);
            check("rr_gap_idle", 32'(busy), 32'd0);
        end
        req = '0;
        repeat (12) @(negedge clk);

        // Abort mid-RUN; outputs must clear without a clock edge.
        req = 4'b0011;
        repeat (5) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_grant",  32'(grant),    32'd0);
        check("abort_done",   32'(done),     32'd0);
        check("abort_busy",   32'(busy),     32'd0);
        check("abort_load",   32'(reg_load), 32'd0);
        check("abort_regin",  32'(reg_in),   32'd0);
        check("abort_result", 32'(result),   32'd0);
        @(negedge clk);
        check("abort_no_done", 32'(done), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_first_grant", 32'(grant), 32'b0001);
        req = '0;
        repeat (12) @(negedge clk);

        // Random phase with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
            if ($urandom_range(0, 2) == 0) seed = 16'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_sched_rr.md
Name: load_sched_rr

Overview:
Round-robin scheduler that shares one loadable WIDTH-bit register (load / in / out datapath) between NREQ requesters. For each granted requester it loads that requester's seed, lets the register run for RUN_CYCLES cycles, then returns the register value with a one-cycle done pulse. It sits between the requesting blocks and the single shared register instance.

Parameters:
NREQ, 4, number of requesters (>=2)
WIDTH, 4, data width of the shared register
RUN_CYCLES, 8, cycles the register runs after load before the result is captured (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
req  input  NREQ  per-requester request level
seed  input  NREQ*WIDTH  per-requester load value; slice i = seed[i*WIDTH +: WIDTH]
grant  output  NREQ  one-hot owner, held from LOAD through DONE
done  output  NREQ  one-cycle completion pulse to the owner
result  output  WIDTH  captured register value; held until the next capture
busy  output  1  high whenever state != IDLE
reg_load  output  1  load strobe to the shared register
reg_in  output  WIDTH  load data to the shared register
reg_out  input  WIDTH  shared register output

Behaviour:
- rst=0 (async, any state): state=IDLE, grant=0, done=0, result=0, reg_load=0, reg_in=0, busy=0, ptr=NREQ-1, run counter=0. An in-flight transaction is abandoned; no done pulse.
- Registered Moore FSM with states IDLE, LOAD, RUN, DONE. All outputs decode from registers.
- IDLE: if req!=0, pick the first set bit searching ptr+1, ptr+2, ... with wrap modulo NREQ. Latch the owner index and seed[owner] into reg_in, then go to LOAD. If req==0, stay in IDLE.
- LOAD (1 cycle): reg_load=1 and reg_in=latched seed. Load run counter=RUN_CYCLES-1, then go to RUN.
- RUN (RUN_CYCLES cycles): reg_load=0. Decrement the counter each cycle. On the edge ending the cycle where counter==0: result<=reg_out, go to DONE.
- DONE (1 cycle): done[owner]=1, ptr<=owner, then go to IDLE.
- grant[owner]=1 in LOAD, RUN and DONE; grant=0 in IDLE.
- Timing: req sampled at the end of IDLE cycle T gives LOAD in T+1, RUN in T+2..T+1+RUN_CYCLES, DONE in T+2+RUN_CYCLES. One transaction every RUN_CYCLES+3 cycles.
- Result value: result is the reg_out value during the final RUN cycle, i.e. the seed after RUN_CYCLES-1 register advances.
- req deasserted after grant: the transaction still completes and done still pulses.
- Seed changes after the IDLE-state latch are ignored.
- req held after done: the requester re-competes. It is regranted back-to-back only if no other requester is active.
- reg_in holds the last latched seed outside LOAD; only reg_load qualifies it.
- No arithmetic is performed on data. The counter width is $clog2(RUN_CYCLES+1).

Decomposition:
- Shared package load_sched_pkg: state encoding constants IDLE=2'b00, LOAD=2'b01, RUN=2'b10, DONE=2'b11.
- Sub-module rr_pick (combinational): inputs req and ptr; outputs valid, owner index and one-hot mask. It is reused by later arbiters.

Test Plan:
Common setup: NREQ=4, WIDTH=4, RUN_CYCLES=8. Bench model is a 4-bit up-counter with load, wrapping mod 16.
1. Assert rst=0 mid-cycle -> grant, done, result, reg_in, reg_load and busy go 0 immediately, without waiting for clk.
2. req=4'b0100, seed[2]=4'h3 in IDLE at T -> grant=4'b0100 from T+1; reg_load=1 only in T+1 with reg_in=4'h3; done=4'b0100 at T+10; result=4'hA.
3. req=4'b1111 held, after reset -> grants in order 0,1,2,3,0, each 11 cycles apart; exactly one done pulse per grant.
4. seed[1]=4'hE, req=4'b0010 -> result=4'h5 (wrap-around); done[1] pulses once.
5. req[3] dropped during RUN -> done[3] still pulses at the scheduled cycle; state returns to IDLE and busy=0 with no new grant.
6. rst=0 during RUN with req=4'b0011, then release -> no done pulse for the aborted owner; first grant goes to req0 (ptr reset to 3).
